wt_dcache_rd_ctrl_fp: RTL and testbench

WT_DCACHE_RD_CTRL_FP -- requirements
Module: wt_dcache_rd_ctrl_fp

---
 rtl/wt_cache_pkg.sv | 18 +
 rtl/wt_dcache_rd_ctrl_fp.sv | 209 ++++++++++++++++++++
 tb/tb_wt_dcache_rd_ctrl_fp.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through data cache read path.
package wt_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MISS_REQ,
    MISS_WAIT,
    KILL_MISS,
    KILL_MISS_ACK,
    REPLAY_REQ,
    REPLAY_READ
  } rd_state_e;

  // Size code that asks the miss unit for a whole cacheline.
  localparam logic [2:0] CL_SIZE = 3'b111;

endpackage

// File: rtl/wt_dcache_rd_ctrl_fp.sv
// Read-port controller: array lookup, miss handoff, replay on readout
// collisions with escalation to a noncacheable forced miss.
module wt_dcache_rd_ctrl_fp
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumWays = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TagWidth = 44,
  parameter int unsigned IdxWidth = 6,
  parameter int unsigned OffWidth = 4,
  parameter int unsigned MaxReplay = 3,
  parameter logic [TagWidth-1:0] CachedTagLo = '0,
  parameter logic [TagWidth-1:0] CachedTagHi = '1,
  parameter int unsigned RdTxId = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cache_en_i,
  input  logic                                  stall_i,
  output logic                                  busy_o,
  input  logic                                  req_i,
  input  logic [IdxWidth+OffWidth-1:0]          index_i,
  input  logic [1:0]                            size_i,
  output logic                                  gnt_o,
  input  logic [TagWidth-1:0]                   tag_i,
  input  logic                                  tag_vld_i,
  input  logic                                  kill_i,
  output logic                                  rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  miss_req_o,
  input  logic                                  miss_ack_i,
  input  logic                                  miss_replay_i,
  input  logic                                  miss_rtrn_i,
  output logic [TagWidth+IdxWidth+OffWidth-1:0] miss_paddr_o,
  output logic                                  miss_nc_o,
  output logic [2:0]                            miss_size_o,
  output logic [NumWays-1:0]                    miss_vld_o,
  input  logic                                  wr_cl_vld_i,
  output logic                                  rd_req_o,
  input  logic                                  rd_ack_i,
  output logic [TagWidth-1:0]                   rd_tag_o,
  output logic [IdxWidth+OffWidth-1:0]          rd_index_o,
  input  logic [DataWidth-1:0]                  rd_data_i,
  input  logic [NumWays-1:0]                    rd_vld_i,
  input  logic [NumWays-1:0]                    rd_hit_oh_i,
  output logic                                  forced_miss_o
);

  localparam int unsigned AddrW = IdxWidth + OffWidth;
  localparam int unsigned CntW = (MaxReplay > 0) ? $clog2(MaxReplay + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxReplay);

  rd_state_e state_q, state_d;
  logic [AddrW-1:0] ix_q, ix_d;
  logic [1:0] size_q, size_d;
  logic [TagWidth-1:0] tag_q, tag_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic forced_q, forced_d;
  logic rd_ack_q, rd_req_q;
  logic [NumWays-1:0] miss_vld_q;
  logic hit, do_replay;

  // Subtraction borrow instead of relational operators keeps the range check
  // free of constant-comparison results when the bounds are 0 or all-ones.
  function automatic logic tag_in_range(input logic [TagWidth-1:0] t);
    logic [TagWidth:0] ge;
    logic [TagWidth:0] le;
    ge = {1'b0, t} - {1'b0, CachedTagLo};
    le = {1'b0, CachedTagHi} - {1'b0, t};
    return !ge[TagWidth] && !le[TagWidth];
  endfunction

  assign tag_d = (state_q == READ && tag_vld_i) ? tag_i : tag_q;
  assign hit = (|rd_hit_oh_i) & cache_en_i & tag_in_range(tag_d) & !forced_q;

  always_comb begin
    state_d = state_q;
    ix_d = ix_q;
    size_d = size_q;
    cnt_d = cnt_q;
    forced_d = forced_q;
    rd_req_o = 1'b0;
    gnt_o = 1'b0;
    rvalid_o = 1'b0;
    miss_req_o = 1'b0;
    forced_miss_o = 1'b0;
    do_replay = 1'b0;

    unique case (state_q)
      IDLE: begin
        rd_req_o = req_i & !stall_i;
        gnt_o = rd_req_o & rd_ack_i;
        if (gnt_o) state_d = READ;
      end
      READ, REPLAY_READ: begin
        rd_req_o = 1'b1;
        if (kill_i) begin
          rvalid_o = 1'b1;
          state_d = IDLE;
        end else if (tag_vld_i || state_q == REPLAY_READ) begin
          if (wr_cl_vld_i || !rd_ack_q) begin
            do_replay = 1'b1;
          end else if (hit) begin
            rvalid_o = 1'b1;
            gnt_o = req_i & rd_ack_i & !stall_i;
            state_d = gnt_o ? READ : IDLE;
          end else begin
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        miss_req_o = 1'b1;
        if (kill_i) begin
          rvalid_o = 1'b1;
          state_d = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
        end else if (miss_replay_i) begin
          do_replay = 1'b1;
        end else if (miss_ack_i) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (miss_rtrn_i) begin
          rvalid_o = 1'b1;
          state_d = IDLE;
        end else if (kill_i) begin
          rvalid_o = 1'b1;
          state_d = KILL_MISS;
        end
      end
      KILL_MISS: begin
        if (miss_rtrn_i) state_d = IDLE;
      end
      KILL_MISS_ACK: begin
        miss_req_o = 1'b1;
        if (miss_replay_i) state_d = IDLE;
        else if (miss_ack_i) state_d = KILL_MISS;
      end
      REPLAY_REQ: begin
        rd_req_o = 1'b1;
        if (kill_i) begin
          rvalid_o = 1'b1;
          state_d = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // The counter stops at the limit, so it saturates without extra logic.
    if (do_replay) begin
      if (cnt_q == MaxCnt) begin
        forced_d = 1'b1;
        forced_miss_o = 1'b1;
        state_d = MISS_REQ;
      end else begin
        cnt_d = cnt_q + CntW'(1);
        state_d = REPLAY_REQ;
      end
    end

    if (gnt_o) begin
      ix_d = index_i;
      size_d = size_i;
      cnt_d = '0;
      forced_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ix_q <= '0;
      size_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      forced_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_req_q <= 1'b0;
      miss_vld_q <= '0;
    end else begin
      state_q <= state_d;
      ix_q <= ix_d;
      size_q <= size_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      forced_q <= forced_d;
      rd_ack_q <= rd_ack_i;
      rd_req_q <= rd_req_o;
      if (rd_req_q) miss_vld_q <= rd_vld_i;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign rd_index_o = ix_d;
  assign rd_tag_o = tag_d;
  assign rdata_o = rd_data_i;
  assign miss_paddr_o = {tag_q, ix_q};
  assign miss_nc_o = !cache_en_i | !tag_in_range(tag_q) | forced_q;
  assign miss_size_o = miss_nc_o ? {1'b0, size_q} : CL_SIZE;
  assign miss_vld_o = miss_vld_q;

  // The transaction ID is consumed by the miss unit, not by this port.
  logic unused_cfg;
  assign unused_cfg = ^{RdTxId};

endmodule

// File: tb/tb_wt_dcache_rd_ctrl_fp.sv
// Directed bench for the dcache read controller with an rdata scoreboard.
module tb_wt_dcache_rd_ctrl_fp;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_en, stall, busy, req, gnt;
  logic [9:0]  index;
  logic [1:0]  size;
  logic [43:0] tag;
  logic        tag_vld, kill, rvalid;
  logic [63:0] rdata;
  logic        miss_req, miss_ack, miss_replay, miss_rtrn;
  logic [53:0] miss_paddr;
  logic        miss_nc;
  logic [2:0]  miss_size;
  logic [3:0]  miss_vld;
  logic        wr_cl_vld, rd_req, rd_ack;
  logic [43:0] rd_tag;
  logic [9:0]  rd_index;
  logic [63:0] rd_data;
  logic [3:0]  rd_vld, rd_hit_oh;
  logic        forced_miss;

  int n_tests = 0;
  int n_fail = 0;
  int gnt_cnt = 0;
  int rv_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  wt_dcache_rd_ctrl_fp #(.MaxReplay(3)) dut (
    .clk_i(clk), .rst_i(rst), .cache_en_i(cache_en), .stall_i(stall),
    .busy_o(busy), .req_i(req), .index_i(index), .size_i(size), .gnt_o(gnt),
    .tag_i(tag), .tag_vld_i(tag_vld), .kill_i(kill), .rvalid_o(rvalid),
    .rdata_o(rdata), .miss_req_o(miss_req), .miss_ack_i(miss_ack),
    .miss_replay_i(miss_replay), .miss_rtrn_i(miss_rtrn),
    .miss_paddr_o(miss_paddr), .miss_nc_o(miss_nc), .miss_size_o(miss_size),
    .miss_vld_o(miss_vld), .wr_cl_vld_i(wr_cl_vld), .rd_req_o(rd_req),
    .rd_ack_i(rd_ack), .rd_tag_o(rd_tag), .rd_index_o(rd_index),
    .rd_data_i(rd_data), .rd_vld_i(rd_vld), .rd_hit_oh_i(rd_hit_oh),
    .forced_miss_o(forced_miss)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Each rvalid retires the oldest outstanding grant.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt) gnt_cnt++;
      if (rvalid) begin
        rv_cnt++;
        chk("rvalid_has_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("rdata", rdata, exp_q.pop_front());
        $display("[TB] t=%0t rvalid rdata=0x%0h", $time, rdata);
      end
    end
  end

  task automatic issue(input logic [9:0] idx, input logic [1:0] sz, input logic [63:0] d);
    req = 1'b1; index = idx; size = sz; rd_ack = 1'b1;
    sample();
    chk("gnt", 64'(gnt), 64'd1);
    chk("rd_index", 64'(rd_index), 64'(idx));
    exp_q.push_back(d);
    $display("[TB] t=%0t grant idx=0x%0h size=%0d", $time, idx, sz);
    tick();
    req = 1'b0; rd_ack = 1'b0;
  endtask

  initial begin
    int fm_at;
    rst = 1'b1; cache_en = 1'b1; stall = 1'b0; req = 1'b0; index = '0; size = '0;
    tag = '0; tag_vld = 1'b0; kill = 1'b0; miss_ack = 1'b0; miss_replay = 1'b0;
    miss_rtrn = 1'b0; wr_cl_vld = 1'b0; rd_ack = 1'b0; rd_data = '0; rd_vld = '0;
    rd_hit_oh = '0;
    tick(); tick();
    sample();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_req", 64'(rd_req), 64'd0);
    chk("rst_miss_req", 64'(miss_req), 64'd0);
    chk("rst_paddr", 64'(miss_paddr), 64'd0);
    chk("rst_miss_size", 64'(miss_size), 64'h7);
    chk("rst_miss_vld", 64'(miss_vld), 64'd0);
    tick();
    rst = 1'b0;

    // Hit
    issue(10'h015, 2'd3, 64'hD1D1_0000_0000_0001);
    tag_vld = 1'b1; tag = 44'h100; rd_hit_oh = 4'b0010; rd_data = 64'hD1D1_0000_0000_0001;
    rd_vld = 4'b1111;
    sample();
    chk("hit_rvalid", 64'(rvalid), 64'd1);
    chk("hit_rd_tag", 64'(rd_tag), 64'h100);
    tick();
    tag_vld = 1'b0; rd_hit_oh = '0;
    sample();
    chk("hit_idle", 64'(busy), 64'd0);
    chk("hit_miss_vld", 64'(miss_vld), 64'hf);

    // Cacheable miss
    tick();
    issue(10'h02A, 2'd2, 64'hD2D2_0000_0000_0002);
    tag_vld = 1'b1; tag = 44'h100; rd_vld = 4'b0101;
    sample();
    chk("miss_no_rvalid", 64'(rvalid), 64'd0);
    tick();
    tag_vld = 1'b0; miss_ack = 1'b1;
    sample();
    chk("miss_req", 64'(miss_req), 64'd1);
    chk("miss_size", 64'(miss_size), 64'h7);
    chk("miss_nc", 64'(miss_nc), 64'd0);
    chk("miss_paddr", 64'(miss_paddr), {10'd0, 44'h100, 10'h02A});
    chk("miss_vld", 64'(miss_vld), 64'h5);
    tick();
    miss_ack = 1'b0;
    sample();
    chk("miss_wait_req", 64'(miss_req), 64'd0);
    chk("miss_wait_busy", 64'(busy), 64'd1);
    tick();
    miss_rtrn = 1'b1; rd_data = 64'hD2D2_0000_0000_0002;
    sample();
    chk("miss_rvalid", 64'(rvalid), 64'd1);
    tick();
    miss_rtrn = 1'b0;

    // Forced miss after three collision replays
    issue(10'h007, 2'd1, 64'hD3D3_0000_0000_0003);
    tag_vld = 1'b1; tag = 44'h200; wr_cl_vld = 1'b1; rd_ack = 1'b1; rd_hit_oh = 4'b0010;
    fm_at = 0;
    for (int i = 1; i <= 20 && fm_at == 0; i++) begin
      sample();
      if (forced_miss) fm_at = i;
      tick();
      tag_vld = 1'b0;
    end
    chk("forced_cycle", 64'(fm_at), 64'd7);
    wr_cl_vld = 1'b0; rd_ack = 1'b0; rd_hit_oh = '0; miss_ack = 1'b1;
    sample();
    chk("forced_pulse_end", 64'(forced_miss), 64'd0);
    chk("forced_miss_req", 64'(miss_req), 64'd1);
    chk("forced_nc", 64'(miss_nc), 64'd1);
    chk("forced_size", 64'(miss_size), 64'd1);
    chk("forced_paddr", 64'(miss_paddr), {10'd0, 44'h200, 10'h007});
    tick();
    miss_ack = 1'b0; miss_rtrn = 1'b1; rd_data = 64'hD3D3_0000_0000_0003;
    sample();
    chk("forced_rvalid", 64'(rvalid), 64'd1);
    tick();
    miss_rtrn = 1'b0;

    // Kill while the miss request is still unacknowledged
    issue(10'h033, 2'd3, 64'hD4D4_0000_0000_0004);
    tag_vld = 1'b1; tag = 44'h180;
    sample();
    tick();
    tag_vld = 1'b0; kill = 1'b1; rd_data = 64'hD4D4_0000_0000_0004;
    sample();
    chk("kill_rvalid", 64'(rvalid), 64'd1);
    tick();
    kill = 1'b0; miss_replay = 1'b1;
    sample();
    chk("kill_ack_miss_req", 64'(miss_req), 64'd1);
    chk("kill_ack_no_rvalid", 64'(rvalid), 64'd0);
    tick();
    miss_replay = 1'b0;
    sample();
    chk("kill_idle", 64'(busy), 64'd0);

    // Back-to-back hits
    tick();
    issue(10'h011, 2'd3, 64'hD5D5_0000_0000_0005);
    tag_vld = 1'b1; tag = 44'h300; rd_hit_oh = 4'b0001; rd_data = 64'hD5D5_0000_0000_0005;
    req = 1'b1; index = 10'h012; rd_ack = 1'b1;
    sample();
    chk("b2b_gnt", 64'(gnt), 64'd1);
    chk("b2b_rvalid", 64'(rvalid), 64'd1);
    chk("b2b_rd_index", 64'(rd_index), 64'h012);
    exp_q.push_back(64'hD6D6_0000_0000_0006);
    tick();
    req = 1'b0; rd_ack = 1'b0; tag = 44'h301; rd_data = 64'hD6D6_0000_0000_0006;
    sample();
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_rvalid2", 64'(rvalid), 64'd1);
    tick();
    tag_vld = 1'b0; rd_hit_oh = '0;

    // Reset during MISS_WAIT drops the transaction
    issue(10'h3C5, 2'd0, 64'hD7D7_0000_0000_0007);
    tag_vld = 1'b1; tag = 44'h0AB;
    sample();
    tick();
    tag_vld = 1'b0; miss_ack = 1'b1;
    sample();
    tick();
    miss_ack = 1'b0; rst = 1'b1;
    sample();
    chk("rst_mid_no_rvalid", 64'(rvalid), 64'd0);
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    gnt_cnt--;
    sample();
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_paddr", 64'(miss_paddr), 64'd0);
    chk("rst_mid_miss_req", 64'(miss_req), 64'd0);
    chk("rst_mid_miss_size", 64'(miss_size), 64'h7);
    chk("rst_mid_miss_vld", 64'(miss_vld), 64'd0);
    tick();
    miss_rtrn = 1'b1;
    sample();
    chk("rst_mid_rtrn_no_rvalid", 64'(rvalid), 64'd0);
    tick();
    miss_rtrn = 1'b0;
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("one_rvalid_per_gnt", 64'(rv_cnt), 64'(gnt_cnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
